// File: rtl/sdio_rx_data_deser.sv
// rtl/sdio_rx_data_deser.sv - SDIO receive-data deserialiser: start-bit detect, byte/word packing, CRC16/end-bit check
// Optional feature macro: SDIO_RX_CRC_CHECK_EN builds the per-line CRC16 generators and comparison.
module sdio_rx_data_deser #(
    parameter int BSIZE_W = 10,
    parameter int BNUM_W  = 8,
    parameter int TO_W    = 16
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               clr_i,
    input  logic               start_i,
    input  logic               quad_i,
    input  logic [BSIZE_W-1:0] block_size_i,
    input  logic [BNUM_W-1:0]  block_num_i,
    input  logic [TO_W-1:0]    timeout_i,
    input  logic [3:0]         sddata_i,
    output logic [31:0]        data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               crc_err_o,
    output logic               timeout_err_o,
    output logic               ovf_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_CRC,
        S_STOP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic               quad_q;
    logic [BSIZE_W-1:0] bsize_q, byte_cnt_q;
    logic [BNUM_W-1:0]  bnum_q, blk_cnt_q;
    logic [TO_W-1:0]    to_q, to_cnt_q;
    logic [2:0]         bit_cnt_q;
    logic [3:0]         crc_cnt_q;
    logic [7:0]         shift_q;
    logic [31:0]        asm_q;
    logic [31:0]        data_q;
    logic               valid_q, crc_err_q, to_err_q, ovf_err_q;

    logic [3:0]         act_lines;
    logic               start_seen, timed_out, byte_done, last_byte, word_done;
    logic               crc_bad, end_bad;
    logic [TO_W-1:0]    to_inc;
    logic [7:0]         byte_new;
    logic [31:0]        word_new;

    assign act_lines  = quad_q ? 4'hF : 4'h1;
    assign start_seen = quad_q ? (sddata_i == 4'h0) : !sddata_i[0];
    assign to_inc     = to_cnt_q + TO_W'(1);
    assign timed_out  = (to_q != '0) && (to_inc == to_q);

    // Bits arrive MSB first; in quad mode the high nibble comes first.
    assign byte_new  = quad_q ? {shift_q[3:0], sddata_i} : {shift_q[6:0], sddata_i[0]};
    assign byte_done = (state_q == S_DATA) && (bit_cnt_q == (quad_q ? 3'd1 : 3'd7));
    assign last_byte = (byte_cnt_q == bsize_q);
    assign word_done = byte_done && ((byte_cnt_q[1:0] == 2'd3) || last_byte);
    assign word_new  = asm_q | (32'(byte_new) << {byte_cnt_q[1:0], 3'b000});
    assign end_bad   = (state_q == S_STOP) && |(act_lines & ~sddata_i);

`ifdef SDIO_RX_CRC_CHECK_EN
    logic [15:0] crc_q [4];
    logic [3:0]  crc_msb;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    assign crc_msb = {crc_q[3][15], crc_q[2][15], crc_q[1][15], crc_q[0][15]};
    assign crc_bad = (state_q == S_CRC) && |(act_lines & (sddata_i ^ crc_msb));

    // All four generators run regardless of mode; only active lines are compared.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 4; i++) crc_q[i] <= '0;
        end else if (clr_i || (state_q == S_WAIT && start_seen)) begin
            for (int i = 0; i < 4; i++) crc_q[i] <= '0;
        end else if (state_q == S_DATA) begin
            for (int i = 0; i < 4; i++) crc_q[i] <= crc16_step(crc_q[i], sddata_i[i]);
        end else if (state_q == S_CRC) begin
            for (int i = 0; i < 4; i++) crc_q[i] <= {crc_q[i][14:0], 1'b0};
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_WAIT;
            S_WAIT: begin
                busy_o = 1'b1;
                if (start_seen)     state_d = S_DATA;
                else if (timed_out) state_d = S_DONE;
            end
            S_DATA: begin
                busy_o = 1'b1;
                if (byte_done && last_byte) state_d = S_CRC;
            end
            S_CRC: begin
                busy_o = 1'b1;
                if (crc_cnt_q == 4'd15) state_d = S_STOP;
            end
            S_STOP: begin
                busy_o  = 1'b1;
                state_d = (blk_cnt_q == bnum_q) ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clr_i) begin
            state_d = S_IDLE;
            busy_o  = 1'b0;
            done_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            quad_q <= 1'b0; bsize_q <= '0; bnum_q <= '0; to_q <= '0;
            byte_cnt_q <= '0; blk_cnt_q <= '0; to_cnt_q <= '0;
            bit_cnt_q <= '0; crc_cnt_q <= '0; shift_q <= '0; asm_q <= '0;
            data_q <= '0; valid_q <= 1'b0;
            crc_err_q <= 1'b0; to_err_q <= 1'b0; ovf_err_q <= 1'b0;
        end else if (clr_i) begin
            quad_q <= 1'b0; bsize_q <= '0; bnum_q <= '0; to_q <= '0;
            byte_cnt_q <= '0; blk_cnt_q <= '0; to_cnt_q <= '0;
            bit_cnt_q <= '0; crc_cnt_q <= '0; shift_q <= '0; asm_q <= '0;
            data_q <= '0; valid_q <= 1'b0;
            crc_err_q <= 1'b0; to_err_q <= 1'b0; ovf_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    quad_q    <= quad_i;
                    bsize_q   <= block_size_i;
                    bnum_q    <= block_num_i;
                    to_q      <= timeout_i;
                    blk_cnt_q <= '0;
                    to_cnt_q  <= '0;
                    crc_err_q <= 1'b0;
                    to_err_q  <= 1'b0;
                    ovf_err_q <= 1'b0;
                end
                S_WAIT: if (start_seen) begin
                    byte_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    crc_cnt_q  <= '0;
                    asm_q      <= '0;
                end else begin
                    to_cnt_q <= to_inc;
                    if (timed_out) to_err_q <= 1'b1;
                end
                S_DATA: begin
                    shift_q <= byte_new;
                    if (byte_done) begin
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= byte_cnt_q + BSIZE_W'(1);
                        asm_q      <= word_done ? 32'h0 : word_new;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                S_CRC: begin
                    crc_cnt_q <= crc_cnt_q + 4'd1;
                    if (crc_bad) crc_err_q <= 1'b1;
                end
                S_STOP: begin
                    if (end_bad) crc_err_q <= 1'b1;
                    blk_cnt_q <= blk_cnt_q + BNUM_W'(1);
                    to_cnt_q  <= '0;
                end
                default: ;
            endcase

            // The card clock cannot be stalled, so a word with nowhere to go is dropped.
            if (word_done) begin
                if (!valid_q || ready_i) begin
                    data_q  <= word_new;
                    valid_q <= 1'b1;
                end else begin
                    ovf_err_q <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o        = data_q;
    assign valid_o       = valid_q;
    assign crc_err_o     = crc_err_q;
    assign timeout_err_o = to_err_q;
    assign ovf_err_o     = ovf_err_q;

endmodule

// File: tb/tb_sdio_rx_data_deser.sv
// tb/tb_sdio_rx_data_deser.sv - scoreboard bench for sdio_rx_data_deser with a bit-level card model
`timescale 1ns/1ps
module tb_sdio_rx_data_deser;

    localparam int BSIZE_W = 10;
    localparam int BNUM_W  = 8;
    localparam int TO_W    = 16;
`ifdef SDIO_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic               clk_i = 1'b0;
    logic               rstn_i, clr_i, start_i, quad_i, ready_i;
    logic [BSIZE_W-1:0] block_size_i;
    logic [BNUM_W-1:0]  block_num_i;
    logic [TO_W-1:0]    timeout_i;
    logic [3:0]         sddata_i;
    logic [31:0]        data_o;
    logic               valid_o, busy_o, done_o, crc_err_o, timeout_err_o, ovf_err_o;

    sdio_rx_data_deser #(.BSIZE_W(BSIZE_W), .BNUM_W(BNUM_W), .TO_W(TO_W)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .clr_i(clr_i), .start_i(start_i), .quad_i(quad_i),
        .block_size_i(block_size_i), .block_num_i(block_num_i), .timeout_i(timeout_i),
        .sddata_i(sddata_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .busy_o(busy_o), .done_o(done_o), .crc_err_o(crc_err_o),
        .timeout_err_o(timeout_err_o), .ovf_err_o(ovf_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ndone = 0;
    int ready_mode = 1;
    logic [31:0] exp_words[$];
    logic [2:0]  exp_flags[$];   // {crc, timeout, ovf} expected at each done_o

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over a word or signals done.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (valid_o && ready_i) begin
                if (exp_words.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got %h expected none", data_o);
                end else begin
                    check("word", data_o, exp_words.pop_front());
                end
            end
            if (done_o) begin
                done_cnt++;
                check("busy_at_done", busy_o, 0);
                if (exp_flags.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    check("flags", {crc_err_o, timeout_err_o, ovf_err_o}, exp_flags.pop_front());
                end
            end
        end
    end

    // Random backpressure never holds ready low for more than three cycles.
    initial begin
        int low_run = 0;
        ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #2;
            if (ready_mode == 0) ready_i = 1'b0;
            else if (ready_mode == 1) ready_i = 1'b1;
            else if (low_run >= 3 || $urandom_range(0, 1) == 1) begin
                ready_i = 1'b1; low_run = 0;
            end else begin
                ready_i = 1'b0; low_run++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drive(input logic [3:0] v);
        sddata_i = v;
        tick();
    endtask

    function automatic logic [15:0] crc_add(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return (c << 1) ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Words are little-endian groups of four bytes; the final group is zero padded.
    task automatic expect_block(input logic [7:0] data[$]);
        for (int w = 0; w < (data.size() + 3) / 4; w++) begin
            logic [31:0] word;
            word = '0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < data.size()) word |= 32'(data[4 * w + k]) << (8 * k);
            exp_words.push_back(word);
        end
    endtask

    task automatic start_xfer(input bit q, input int bsize, input int bnum, input int to);
        quad_i       = q;
        block_size_i = BSIZE_W'(bsize);
        block_num_i  = BNUM_W'(bnum);
        timeout_i    = TO_W'(to);
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Card side: start bit, payload, per-line CRC16, end bit.
    task automatic send_block(input bit q, input logic [7:0] data[$], input int flip_line,
                              input int flip_bit, input int bad_end_line);
        logic [15:0] crc [4];
        logic [3:0]  v;
        for (int i = 0; i < 4; i++) crc[i] = '0;
        drive(q ? 4'h0 : {3'($urandom), 1'b0});
        foreach (data[b]) begin
            if (q) begin
                for (int h = 0; h < 2; h++) begin
                    v = (h == 0) ? data[b][7:4] : data[b][3:0];
                    for (int i = 0; i < 4; i++) crc[i] = crc_add(crc[i], v[i]);
                    drive(v);
                end
            end else begin
                for (int k = 7; k >= 0; k--) begin
                    v = {3'($urandom), data[b][k]};
                    crc[0] = crc_add(crc[0], v[0]);
                    drive(v);
                end
            end
        end
        for (int k = 15; k >= 0; k--) begin
            v = q ? {crc[3][k], crc[2][k], crc[1][k], crc[0][k]} : {3'($urandom), crc[0][k]};
            if (k == flip_bit) v[flip_line] = ~v[flip_line];
            drive(v);
        end
        v = q ? 4'hF : {3'($urandom), 1'b1};
        if (bad_end_line >= 0) v[bad_end_line] = 1'b0;
        drive(v);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        sddata_i = 4'hF;
        while (done_cnt < target && n < 2000) begin tick(); n++; end
        check("done_count", done_cnt, target);
        n = 0;
        while (exp_words.size() != 0 && n < 200) begin tick(); n++; end
        check("words_drained", exp_words.size(), 0);
        tick();
    endtask

    task automatic rand_xfer();
        bit q;
        int bsize, bnum, to;
        bit crc_e, end_e;
        q = 1'($urandom_range(0, 1));
        bsize = $urandom_range(0, 10);
        bnum  = $urandom_range(0, 2);
        to    = ($urandom_range(0, 1) == 1) ? 0 : 300;
        crc_e = 1'b0; end_e = 1'b0;
        start_xfer(q, bsize, bnum, to);
        for (int b = 0; b <= bnum; b++) begin
            logic [7:0] d[$];
            int fl, fb, be;
            fl = 0; fb = -1; be = -1;
            for (int i = 0; i <= bsize; i++) d.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                fl = q ? $urandom_range(0, 3) : 0; fb = $urandom_range(0, 15); crc_e = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) begin
                be = q ? $urandom_range(0, 3) : 0; end_e = 1'b1;
            end
            expect_block(d);
            repeat ($urandom_range(0, 4)) drive(4'hF);
            if (b == bnum) exp_flags.push_back({(crc_e && CRC_EN) || end_e, 1'b0, 1'b0});
            send_block(q, d, fl, fb, be);
        end
        ndone++;
        wait_done(ndone);
    endtask

    initial begin
        logic [7:0] d[$];
        int cyc;
        rstn_i = 1'b0; clr_i = 1'b0; start_i = 1'b0; quad_i = 1'b0;
        block_size_i = '0; block_num_i = '0; timeout_i = '0; sddata_i = 4'hF;
        repeat (3) tick();
        check("reset_outputs", {data_o, valid_o, busy_o, done_o, crc_err_o, timeout_err_o, ovf_err_o}, 0);
        rstn_i = 1'b1;
        tick();

        // 1-bit, one 4-byte block, clean CRC.
        start_xfer(0, 3, 0, 0);
        check("busy_armed", busy_o, 1);
        d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp_words.push_back(32'hEFBEADDE);
        exp_flags.push_back(3'b000);
        send_block(0, d, 0, -1, -1);
        ndone++; wait_done(ndone);

        // Quad, two 5-byte blocks: partial words never span blocks.
        start_xfer(1, 4, 1, 0);
        exp_words.push_back(32'h04030201); exp_words.push_back(32'h00000005);
        exp_words.push_back(32'h09080706); exp_words.push_back(32'h0000000A);
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_block(1, d, 0, -1, -1);
        d = '{8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        exp_flags.push_back(3'b000);
        send_block(1, d, 0, -1, -1);
        ndone++; wait_done(ndone);

        // CRC bit 7 flipped: word still delivered.
        start_xfer(0, 3, 0, 0);
        d = '{8'h12, 8'h34, 8'h56, 8'h78};
        exp_words.push_back(32'h78563412);
        exp_flags.push_back({CRC_EN, 2'b00});
        send_block(0, d, 0, 7, -1);
        ndone++; wait_done(ndone);

        // Timeout of 20 cycles with idle lines.
        exp_flags.push_back(3'b010);
        start_xfer(0, 3, 0, 20);
        cyc = 0;
        while (cyc < 60) begin
            @(negedge clk_i);
            if (done_o) break;
            cyc++;
        end
        check("timeout_cycle", cyc, 20);
        ndone++; wait_done(ndone);

        // Overflow: ready low, first word held, later words dropped.
        ready_mode = 0;
        tick(); tick();
        start_xfer(1, 11, 0, 0);
        d = {};
        for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
        exp_words.push_back({d[3], d[2], d[1], d[0]});
        exp_flags.push_back(3'b001);
        send_block(1, d, 0, -1, -1);
        sddata_i = 4'hF;
        cyc = 0;
        while (done_cnt <= ndone && cyc < 100) begin tick(); cyc++; end
        ndone++;
        @(negedge clk_i);
        check("ovf_hold_valid", valid_o, 1);
        check("ovf_hold_data", data_o, {d[3], d[2], d[1], d[0]});
        ready_mode = 1;
        wait_done(ndone);

        // Asynchronous reset in the middle of the second block.
        ready_mode = 0;
        tick(); tick();
        start_xfer(0, 3, 1, 0);
        d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_block(0, d, 0, 3, -1);
        drive(4'hE);
        repeat (10) drive(4'($urandom));
        check("pre_reset_valid", valid_o, 1);
        check("pre_reset_crc", crc_err_o, CRC_EN);
        #1 rstn_i = 1'b0;
        #1 check("mid_reset_outputs",
                 {data_o, valid_o, busy_o, done_o, crc_err_o, timeout_err_o, ovf_err_o}, 0);
        exp_words.delete();
        exp_flags.delete();
        tick();
        rstn_i = 1'b1;
        ready_mode = 1;
        tick();
        start_xfer(0, 3, 0, 0);
        d = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
        exp_words.push_back(32'hF00FC35A);
        exp_flags.push_back(3'b000);
        send_block(0, d, 0, -1, -1);
        ndone++; wait_done(ndone);

        // Synchronous clear drops an armed transfer.
        start_xfer(1, 7, 0, 0);
        drive(4'h0);
        drive(4'h3);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("clr_idle", {busy_o, valid_o, crc_err_o, timeout_err_o, ovf_err_o}, 0);
        tick();

        // Randomised transfers with backpressure.
        ready_mode = 2;
        repeat (25) rand_xfer();
        ready_mode = 1;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
